game_2048_sequencer: RTL and testbench
======================================

# game_2048_sequencer

Top-level move sequencer for the 2048 game. It owns the registered 4x4 board, turns button presses into single directional moves, and drives the combinational move datapath one direction at a time. It commits the datapath result, spawns a new tile after every board-changing move, and latches win/lose for the VGA renderer.

## Interface
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `btn_izquierda`, `btn_derecha`, `btn_abajo`, `btn_arriba` input 1 each: level buttons, already synchronized and debounced, active-high.
- `condicion_gane` input 4: win exponent; a tile with exponent ≥ this value wins.
- `board_next` input 64: datapath result for `movement` applied to `board_q`.
- `gano_in`, `perdio_in` input 1: datapath win/lose flags for the current `board_q` and `condicion_gane`.
- `movement` output 3: direction presented to the datapath. 0 none, 1 left, 2 right, 3 down, 4 up.
- `board_q` output 64: registered board, 16 cells × 4-bit exponent. 0 is empty, k is tile 2^k. Cell (r,c) sits at bits [4*(4r+c)+:4].
- `busy` output 1: sequencer is not in IDLE.
- `gano`, `perdio` output 1: latched game result.
- `move_count` output 16: count of committed board-changing moves, saturating.

## Operation
- States: INIT0, INIT1, IDLE, APPLY, COMMIT, SPAWN, CHECK, WON, LOST.
- Reset (`rst`=0): all outputs and registers are 0, LFSR=SEED, state=INIT0.
- INIT0/INIT1: each runs one spawn scan (same rules as SPAWN), then goes INIT1→IDLE.
- Button edges are registered per button as `btn & ~btn_d`. In IDLE, exactly one edge starts a move. Zero edges, or two or more edges in the same cycle, are ignored. Edges while `busy`=1 are dropped, not queued. Holding a button gives one move only.
- IDLE→APPLY: `movement` loads the direction code.
- APPLY→COMMIT: `board_next` is sampled.
- COMMIT:
  - If `board_next`==`board_q`, this is a no-op move: no commit, no spawn, `move_count` unchanged, go to IDLE.
  - Otherwise load `board_q`←`board_next`, increment `move_count` (saturates at 16'hFFFF), go to SPAWN.
- SPAWN: start index = LFSR[3:0]. Check one cell per cycle, incrementing mod 16. At the first empty cell, write the spawn value and go to CHECK. If 16 cells are checked with none empty, go to CHECK with no write.
- CHECK: `movement`=0. Sample `gano_in`/`perdio_in`. gano_in → WON; else perdio_in → LOST; else IDLE. Win takes priority if both are set.
- WON/LOST: terminal. `gano`/`perdio` held at 1, buttons ignored. Only `rst` exits.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state.
- Changing `condicion_gane` mid-game affects only the next CHECK.

## Timing
- Edge at cycle t (input sampled high, previous sample low) → IDLE sees the edge at t+1 → APPLY t+2 → COMMIT t+3 → SPAWN from t+4, 1–16 cycles → CHECK → IDLE.
- Worst case press-to-IDLE is 22 cycles.
- `movement` is non-zero only in APPLY and COMMIT.
- `board_q` changes only in COMMIT, in a SPAWN write cycle, or in INIT.
- The datapath must settle within one cycle (combinational path).
- Asserting `rst` mid-sequence clears immediately. The board never holds a half-applied move.

## Configuration
- `SPAWN_FOUR_EN` defined: spawn value is 2 (tile 4) when LFSR[7:4]==0 and LFSR[8]==0 (1/32), otherwise 1.
- `SPAWN_FOUR_EN` undefined: spawn value is always 1 (tile 2). The LFSR sequence is unchanged.

## Structure
- Package `game_2048_pkg`:
  - `dir_t` enum (NONE=0, LEFT=1, RIGHT=2, DOWN=3, UP=4)
  - `seq_state_t`
  - `tile_t` (logic [3:0])
  - `BOARD_W`=64
  - `N_CELLS`=16
- Sub-module `spawn_lfsr`: 16-bit LFSR with SEED parameter, outputs the current state.

## Test plan
- Reset release with SEED default → after INIT exactly two cells are non-zero, each value 1; `busy` drops to 0 within 34 cycles; `move_count`=0.
- Left pulse, datapath model returns a changed board → `movement`=1 for 2 cycles, `board_q`=model board plus one new tile of value 1, `move_count`=1.
- Right pulse where the model returns an identical board → no spawn, `move_count` unchanged, IDLE 3 cycles after the edge was seen.
- Left and up edges in the same cycle, then a held button for 100 cycles → no move from the simultaneous edges; one move only from the held button; presses during `busy` dropped.
- Move producing exponent 11 with `condicion_gane`=11 → `gano`=1 after CHECK; later presses ignored; `rst` low mid-SPAWN clears everything.
- Full board with no merges, `perdio_in`=1 → SPAWN scans 16 cycles without writing, `perdio`=1, state LOST.

Source files
------------

// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 move sequencer and its helpers.
package game_2048_pkg;

    localparam int BOARD_W = 64;
    localparam int N_CELLS = 16;
    localparam int TILE_W  = 4;

    typedef logic [TILE_W-1:0] tile_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        DOWN  = 3'd3,
        UP    = 3'd4
    } dir_t;

    // Plain constants keep the encoding stable for tools that dislike enum state registers.
    typedef logic [3:0] seq_state_t;

    localparam seq_state_t ST_INIT0  = 4'd0;
    localparam seq_state_t ST_INIT1  = 4'd1;
    localparam seq_state_t ST_IDLE   = 4'd2;
    localparam seq_state_t ST_APPLY  = 4'd3;
    localparam seq_state_t ST_COMMIT = 4'd4;
    localparam seq_state_t ST_SPAWN  = 4'd5;
    localparam seq_state_t ST_CHECK  = 4'd6;
    localparam seq_state_t ST_WON    = 4'd7;
    localparam seq_state_t ST_LOST   = 4'd8;

    function automatic logic is_scan_state(input seq_state_t s);
        return (s == ST_INIT0) || (s == ST_INIT1) || (s == ST_SPAWN);
    endfunction

endpackage

// File: rtl/game_2048_sequencer_lfsr.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) that free-runs from SEED.
module spawn_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
    always_comb begin
        feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d   = {feedback, lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/game_2048_sequencer.sv
// 2048 move sequencer: owns the board, issues one move per button press, spawns tiles, latches win/lose.
// Optional feature: define SPAWN_FOUR_EN to let roughly 1 in 32 spawns be a 4 instead of a 2.
module game_2048_sequencer
    import game_2048_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_izquierda,
    input  logic               btn_derecha,
    input  logic               btn_abajo,
    input  logic               btn_arriba,
    input  logic [3:0]         condicion_gane,
    input  logic [BOARD_W-1:0] board_next,
    input  logic               gano_in,
    input  logic               perdio_in,
    output logic [2:0]         movement,
    output logic [BOARD_W-1:0] board_q,
    output logic               busy,
    output logic               gano,
    output logic               perdio,
    output logic [15:0]        move_count
);

    localparam logic [3:0] LAST_SCAN = 4'd15;

    seq_state_t         state_q, state_d;
    logic [BOARD_W-1:0] board_d;
    logic [BOARD_W-1:0] sampled_q, sampled_d;
    logic [3:0]         btn_vec, btn_d_q, edge_q;
    logic [2:0]         movement_q, movement_d;
    logic [3:0]         scan_idx_q, scan_idx_d;
    logic [3:0]         scan_cnt_q, scan_cnt_d;
    logic [15:0]        count_q, count_d;
    logic               busy_q;
    logic               gano_q, gano_d;
    logic               perdio_q, perdio_d;
    logic [15:0]        lfsr;
    tile_t              cells [N_CELLS];
    logic [3:0]         probe_idx;
    logic               probe_empty;
    tile_t              spawn_val;
    logic               single_edge;
    dir_t               edge_dir;
    logic               unused_bits;

    spawn_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .lfsr_o(lfsr)
    );

    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cells
        assign cells[gi] = board_q[TILE_W*gi +: TILE_W];
    end

    assign btn_vec = {btn_arriba, btn_abajo, btn_derecha, btn_izquierda};

`ifdef SPAWN_FOUR_EN
    assign spawn_val   = ((lfsr[7:4] == 4'd0) && !lfsr[8]) ? tile_t'(2) : tile_t'(1);
    assign unused_bits = ^{condicion_gane, lfsr[15:9]};
`else
    assign spawn_val   = tile_t'(1);
    assign unused_bits = ^{condicion_gane, lfsr[15:4]};
`endif

    // The first probe of a scan starts at the live LFSR nibble; later probes walk forward.
    assign probe_idx   = (scan_cnt_q == 4'd0) ? lfsr[3:0] : scan_idx_q;
    assign probe_empty = (cells[probe_idx] == tile_t'(0));

    always_comb begin
        single_edge = (edge_q != 4'd0) && ((edge_q & (edge_q - 4'd1)) == 4'd0);
        edge_dir    = NONE;
        if (edge_q[0]) begin
            edge_dir = LEFT;
        end else if (edge_q[1]) begin
            edge_dir = RIGHT;
        end else if (edge_q[2]) begin
            edge_dir = DOWN;
        end else if (edge_q[3]) begin
            edge_dir = UP;
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        sampled_d  = sampled_q;
        movement_d = 3'd0;
        scan_idx_d = scan_idx_q;
        scan_cnt_d = scan_cnt_q;
        count_d    = count_q;
        gano_d     = gano_q;
        perdio_d   = perdio_q;

        case (state_q)
            ST_INIT0, ST_INIT1, ST_SPAWN: begin
                if (probe_empty || (scan_cnt_q == LAST_SCAN)) begin
                    if (probe_empty) begin
                        board_d[{probe_idx, 2'b00} +: TILE_W] = spawn_val;
                    end
                    scan_cnt_d = 4'd0;
                    if (state_q == ST_INIT0) begin
                        state_d = ST_INIT1;
                    end else if (state_q == ST_INIT1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    scan_idx_d = probe_idx + 4'd1;
                    scan_cnt_d = scan_cnt_q + 4'd1;
                end
            end

            ST_IDLE: begin
                if (single_edge) begin
                    movement_d = edge_dir;
                    state_d    = ST_APPLY;
                end
            end

            ST_APPLY: begin
                movement_d = movement_q;
                sampled_d  = board_next;
                state_d    = ST_COMMIT;
            end

            // An unchanged result means the move was impossible: no commit, no spawn.
            ST_COMMIT: begin
                if (sampled_q == board_q) begin
                    state_d = ST_IDLE;
                end else begin
                    board_d = sampled_q;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    state_d = ST_SPAWN;
                end
            end

            ST_CHECK: begin
                if (gano_in) begin
                    gano_d  = 1'b1;
                    state_d = ST_WON;
                end else if (perdio_in) begin
                    perdio_d = 1'b1;
                    state_d  = ST_LOST;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WON, ST_LOST: begin
                state_d = state_q;
            end

            default: begin
                state_d = ST_INIT0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT0;
            board_q    <= '0;
            sampled_q  <= '0;
            btn_d_q    <= 4'd0;
            edge_q     <= 4'd0;
            movement_q <= 3'd0;
            scan_idx_q <= 4'd0;
            scan_cnt_q <= 4'd0;
            count_q    <= 16'd0;
            busy_q     <= 1'b0;
            gano_q     <= 1'b0;
            perdio_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            sampled_q  <= sampled_d;
            btn_d_q    <= btn_vec;
            edge_q     <= btn_vec & ~btn_d_q;
            movement_q <= movement_d;
            scan_idx_q <= scan_idx_d;
            scan_cnt_q <= scan_cnt_d;
            count_q    <= count_d;
            busy_q     <= (state_d != ST_IDLE);
            gano_q     <= gano_d;
            perdio_q   <= perdio_d;
        end
    end

    assign movement   = movement_q;
    assign busy       = busy_q;
    assign gano       = gano_q;
    assign perdio     = perdio_q;
    assign move_count = count_q;

    a_movement_window: assert property (@(posedge clk) disable iff (!rst)
        ((state_q != ST_APPLY) && (state_q != ST_COMMIT)) |-> (movement_q == 3'd0));

    a_scan_count_idle: assert property (@(posedge clk) disable iff (!rst)
        !is_scan_state(state_q) |-> (scan_cnt_q == 4'd0));

    a_state_legal: assert property (@(posedge clk) disable iff (!rst)
        state_q <= ST_LOST);

endmodule

// File: tb/tb_game_2048_sequencer.sv
// Bench for game_2048_sequencer: table-driven presses, hand-written corner sequences and random play.
`timescale 1ns/1ps
module tb_game_2048_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_izquierda = 1'b0, btn_derecha = 1'b0, btn_abajo = 1'b0, btn_arriba = 1'b0;
    logic [3:0]  condicion_gane = 4'd11;
    logic [63:0] board_next;
    logic        gano_in, perdio_in;
    logic [2:0]  movement;
    logic [63:0] board_q;
    logic        busy, gano, perdio;
    logic [15:0] move_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          dp_mode = 0;
    logic [63:0] forced_board = '0;
    logic        lose_flag = 1'b0;

    logic [63:0] m_board;
    int          m_count;
    logic        m_won, m_lost;

    game_2048_sequencer #(.SEED(SEED)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_izquierda (btn_izquierda),
        .btn_derecha   (btn_derecha),
        .btn_abajo     (btn_abajo),
        .btn_arriba    (btn_arriba),
        .condicion_gane(condicion_gane),
        .board_next    (board_next),
        .gano_in       (gano_in),
        .perdio_in     (perdio_in),
        .movement      (movement),
        .board_q       (board_q),
        .busy          (busy),
        .gano          (gano),
        .perdio        (perdio),
        .move_count    (move_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // LFSR value during the k-th cycle after reset release.
    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s;
    endfunction

    function automatic logic [3:0] spawn_value(input logic [15:0] l);
`ifdef SPAWN_FOUR_EN
        return ((l[7:4] == 4'd0) && !l[8]) ? 4'd2 : 4'd1;
`else
        return (l == 16'd0) ? 4'd1 : 4'd1;
`endif
    endfunction

    // Reference 2048 slide/merge: left toward column 0, down toward row 3.
    function automatic logic [63:0] slide(input logic [63:0] b, input logic [2:0] dir);
        logic [63:0] out;
        int idx[4];
        int tmp[4];
        int res[4];
        int n, o, i, v;
        out = b;
        for (int line = 0; line < 4; line++) begin
            for (int k = 0; k < 4; k++) begin
                case (dir)
                    3'd1:    idx[k] = 4*line + k;
                    3'd2:    idx[k] = 4*line + (3 - k);
                    3'd3:    idx[k] = 4*(3 - k) + line;
                    default: idx[k] = 4*k + line;
                endcase
                res[k] = 0;
                tmp[k] = 0;
            end
            n = 0;
            for (int k = 0; k < 4; k++) begin
                v = int'(b[4*idx[k] +: 4]);
                if (v != 0) begin
                    tmp[n] = v;
                    n++;
                end
            end
            o = 0;
            i = 0;
            while (i < n) begin
                if ((i + 1 < n) && (tmp[i] == tmp[i+1])) begin
                    res[o] = (tmp[i] + 1 > 15) ? 15 : tmp[i] + 1;
                    i += 2;
                end else begin
                    res[o] = tmp[i];
                    i += 1;
                end
                o++;
            end
            for (int k = 0; k < 4; k++) out[4*idx[k] +: 4] = 4'(res[k]);
        end
        return out;
    endfunction

    function automatic logic [63:0] dp_eval(input logic [63:0] b, input logic [2:0] mv,
                                            input int mode, input logic [63:0] forced);
        if (mode == 1 || mv == 3'd0) return b;
        if (mode == 2) return forced;
        return slide(b, mv);
    endfunction

    function automatic logic wins(input logic [63:0] b, input logic [3:0] cond);
        logic w;
        w = 1'b0;
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0 && b[4*i +: 4] >= cond) w = 1'b1;
        return w;
    endfunction

    // First empty cell at or after the LFSR start nibble receives the new tile.
    function automatic logic [63:0] spawn_model(input logic [63:0] b, input int k, output int cycles);
        logic [63:0] out;
        logic [15:0] l0;
        logic        found;
        int          c;
        out    = b;
        cycles = 16;
        found  = 1'b0;
        l0     = lfsr_at(k);
        for (int i = 0; i < 16; i++) begin
            c = (int'(l0[3:0]) + i) % 16;
            if (!found && b[4*c +: 4] == 4'd0) begin
                out[4*c +: 4] = spawn_value(lfsr_at(k + i));
                cycles = i + 1;
                found  = 1'b1;
            end
        end
        return out;
    endfunction

    function automatic logic [2:0] mask_code(input logic [3:0] m);
        int ones;
        logic [2:0] code;
        ones = 0;
        code = 3'd0;
        for (int i = 0; i < 4; i++) if (m[i]) begin
            ones++;
            code = 3'(i + 1);
        end
        return (ones == 1) ? code : 3'd0;
    endfunction

    always_comb board_next = dp_eval(board_q, movement, dp_mode, forced_board);
    always_comb gano_in    = wins(board_q, condicion_gane);
    assign perdio_in = lose_flag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] v);
        btn_izquierda = v[0];
        btn_derecha   = v[1];
        btn_abajo     = v[2];
        btn_arriba    = v[3];
    endtask

    task automatic do_reset();
        int m1, m2, obs, nz;
        logic [63:0] b;
        @(negedge clk);
        rst = 1'b0;
        set_btns(4'd0);
        repeat (2) @(negedge clk);
        chk("rst_board", board_q, 64'd0);
        chk("rst_count", 64'(move_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_movement", 64'(movement), 64'd0);
        chk("rst_gano", 64'(gano), 64'd0);
        chk("rst_perdio", 64'(perdio), 64'd0);
        rst = 1'b1;
        b = spawn_model(64'd0, 0, m1);
        b = spawn_model(b, m1, m2);
        m_board = b;
        m_count = 0;
        m_won   = 1'b0;
        m_lost  = 1'b0;
        obs = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (obs < 0 && !busy) obs = cyc;
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (board_q[4*i +: 4] != 4'd0) nz++;
        chk("init_idle_cycle", 64'(obs), 64'(m1 + m2));
        chk("init_board", board_q, m_board);
        chk("init_tiles", 64'(nz), 64'd2);
        chk("init_count", 64'(move_count), 64'd0);
        $display("init board=%h idle_at=%0d", board_q, obs);
    endtask

    // One press transaction; exp_code is the direction the sequencer must issue (0 = ignored).
    task automatic press(input logic [3:0] mask, input int hold, input logic [3:0] extra,
                         input logic [2:0] exp_code, input string tag);
        int n, m, exp_done, obs_done;
        logic acc;
        logic [63:0] nb, exp_b;
        n        = cyc;
        acc      = (exp_code != 3'd0) && !m_won && !m_lost;
        exp_done = 2;
        exp_b    = m_board;
        if (acc) begin
            nb = dp_eval(m_board, exp_code, dp_mode, forced_board);
            if (nb == m_board) begin
                exp_done = 4;
            end else begin
                if (m_count < 65535) m_count++;
                exp_b    = spawn_model(nb, n + 4, m);
                exp_done = 5 + m;
                if (wins(exp_b, condicion_gane)) m_won = 1'b1;
                else if (lose_flag)              m_lost = 1'b1;
            end
        end
        m_board  = exp_b;
        obs_done = -1;
        set_btns(mask);
        for (int i = 1; i <= hold + 40; i++) begin
            @(negedge clk);
            set_btns(((i < hold) ? mask : 4'd0) | ((i == 2) ? extra : 4'd0));
            if (i == 2 || i == 3) chk({tag, "_movement"}, 64'(movement), 64'(acc ? exp_code : 3'd0));
            if (i == 4) chk({tag, "_movement_off"}, 64'(movement), 64'd0);
            if (obs_done < 0 && i >= 2 && (!busy || gano || perdio)) obs_done = i;
        end
        chk({tag, "_done_cycle"}, 64'(obs_done), 64'(exp_done));
        chk({tag, "_board"}, board_q, m_board);
        chk({tag, "_count"}, 64'(move_count), 64'(m_count));
        chk({tag, "_gano"}, 64'(gano), 64'(m_won));
        chk({tag, "_perdio"}, 64'(perdio), 64'(m_lost));
        chk({tag, "_busy"}, 64'(busy), 64'(m_won | m_lost));
        $display("press %s mask=%b code=%0d done=%0d board=%h count=%0d", tag, mask, exp_code,
                 obs_done, board_q, move_count);
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [2:0] code;
    } vec_t;

    vec_t        tbl [8];
    logic [63:0] pattern;
    int          n0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0001, 3'd1};
        tbl[1] = '{4'b0010, 3'd2};
        tbl[2] = '{4'b0100, 3'd3};
        tbl[3] = '{4'b1000, 3'd4};
        tbl[4] = '{4'b1001, 3'd0};
        tbl[5] = '{4'b0011, 3'd0};
        tbl[6] = '{4'b1111, 3'd0};
        tbl[7] = '{4'b0000, 3'd0};

        do_reset();

        dp_mode = 0;
        for (int t = 0; t < 8; t++) press(tbl[t].mask, 1, 4'd0, tbl[t].code, $sformatf("tbl%0d", t));

        dp_mode = 1;
        press(4'b0010, 1, 4'd0, 3'd2, "noop_right");

        dp_mode      = 2;
        forced_board = 64'h0000_1000_0200_0031;
        press(4'b0100, 100, 4'b0010, 3'd3, "held_down");

        dp_mode = 0;
        for (int r = 0; r < 30; r++) begin
            logic [3:0] mk;
            if ($urandom_range(0, 9) < 8) mk = 4'(1 << $urandom_range(0, 3));
            else                          mk = 4'($urandom_range(0, 15));
            press(mk, int'($urandom_range(1, 3)), 4'd0, mask_code(mk), $sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Full board with no merges: scan visits all 16 cells without writing.
        pattern = '0;
        for (int i = 0; i < 16; i++) pattern[4*i +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
        dp_mode      = 2;
        forced_board = pattern;
        lose_flag    = 1'b1;
        press(4'b0001, 1, 4'd0, 3'd1, "lose");
        press(4'b0010, 1, 4'd0, 3'd2, "after_lose");
        lose_flag = 1'b0;

        do_reset();
        pattern = '0;
        pattern[4*5 +: 4] = 4'd11;
        pattern[4*6 +: 4] = 4'd3;
        forced_board = pattern;
        press(4'b0001, 1, 4'd0, 3'd1, "win");
        press(4'b1000, 1, 4'd0, 3'd4, "after_win");

        // Reset asserted in the first SPAWN cycle must clear the committed move at once.
        do_reset();
        forced_board = 64'hFEDC_BA98_7654_3210 & 64'h3333_3333_3333_3330;
        n0 = cyc;
        set_btns(4'b0001);
        repeat (4) @(negedge clk);
        set_btns(4'd0);
        chk("midspawn_cycle", 64'(cyc - n0), 64'd4);
        chk("midspawn_board", board_q, forced_board);
        chk("midspawn_count", 64'(move_count), 64'd1);
        rst = 1'b0;
        #1;
        chk("midspawn_rst_board", board_q, 64'd0);
        chk("midspawn_rst_count", 64'(move_count), 64'd0);
        chk("midspawn_rst_busy", 64'(busy), 64'd0);
        chk("midspawn_rst_movement", 64'(movement), 64'd0);
        $display("midspawn reset board=%h count=%0d", board_q, move_count);
        dp_mode = 0;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
